// File: rtl/mem_ctrl_pkg.sv
// Shared opcode, state and geometry definitions for the burst memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b11
  } op_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_STARTUP   = 3'd0;
  localparam state_t ST_IDLE      = 3'd1;
  localparam state_t ST_RD_REQ    = 3'd2;
  localparam state_t ST_RD_DRAIN  = 3'd3;
  localparam state_t ST_WR_FILL   = 3'd4;
  localparam state_t ST_WR_BUBBLE = 3'd5;
  localparam state_t ST_WR_REQ    = 3'd6;

  localparam int DEF_WORD_SIZE     = 32;
  localparam int DEF_CL_SIZE_WIDTH = 512;
  localparam int FILL_COUNT        = DEF_CL_SIZE_WIDTH / DEF_WORD_SIZE;
  localparam int LINE_BYTES        = DEF_CL_SIZE_WIDTH / 8;

endpackage

// File: rtl/mem_ctrl_burst_line_buffer_wordport.sv
// One cache line of storage: word-indexed write and read ports plus a full-line load.
module line_buffer_wordport #(
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 512,
  localparam int WORDS = CL_SIZE_WIDTH / WORD_SIZE,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [CL_SIZE_WIDTH-1:0] load_data,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [WORD_SIZE-1:0]     wr_data,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [WORD_SIZE-1:0]     rd_data,
  output logic [CL_SIZE_WIDTH-1:0] line
);

  logic [CL_SIZE_WIDTH-1:0] line_q;

  // A full-line load from the host wins over a CPU word write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load_en) begin
      line_q <= load_data;
    end else if (wr_en) begin
      line_q[int'(wr_idx) * WORD_SIZE +: WORD_SIZE] <= wr_data;
    end
  end

  assign rd_data = line_q[int'(rd_idx) * WORD_SIZE +: WORD_SIZE];
  assign line    = line_q;

endmodule

// File: rtl/mem_ctrl_burst.sv
// Multi-line burst controller bridging the CPU word bus (valid/ready) and the host line DMA port.
module mem_ctrl_burst
  import mem_ctrl_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int CL_SIZE_WIDTH = DEF_CL_SIZE_WIDTH,
  parameter int ADDR_BITCOUNT = 64,
  parameter int MAX_BURST     = 8,
  parameter int BUBBLE_CYCLES = 1,
  localparam int LEN_W = $clog2(MAX_BURST) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_init,
  input  logic                     host_rd_ready,
  input  logic                     host_wr_ready,
  input  logic [1:0]               op,
  input  logic                     req_valid,
  input  logic [LEN_W-1:0]         burst_len,
  input  logic [ADDR_BITCOUNT-1:0] raw_address,
  input  logic [ADDR_BITCOUNT-1:0] address_offset,
  input  logic [WORD_SIZE-1:0]     cpu_wdata,
  input  logic                     cpu_wvalid,
  output logic                     cpu_wready,
  output logic [WORD_SIZE-1:0]     cpu_rdata,
  output logic                     cpu_rvalid,
  input  logic                     cpu_rready,
  input  logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in,
  output logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out,
  output logic [ADDR_BITCOUNT-1:0] corrected_address,
  output logic                     ready,
  output logic                     busy,
  output logic                     tx_done,
  output logic                     host_rgo,
  output logic                     host_wgo,
  output logic                     host_re,
  output logic                     host_we,
  output logic                     err_len
);

  localparam int WORDS  = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BUB_W  = $clog2(BUBBLE_CYCLES) + 1;

  localparam logic [WIDX_W-1:0]        LAST_WORD   = WIDX_W'(WORDS - 1);
  localparam logic [WIDX_W-1:0]        WORD_ONE    = WIDX_W'(1);
  localparam logic [LEN_W-1:0]         MAX_LEN     = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0]         LEN_ONE     = LEN_W'(1);
  localparam logic [BUB_W-1:0]         LAST_BUBBLE = BUB_W'(BUBBLE_CYCLES - 1);
  localparam logic [BUB_W-1:0]         BUB_ONE     = BUB_W'(1);
  localparam logic [ADDR_BITCOUNT-1:0] LINE_STEP   = ADDR_BITCOUNT'(CL_SIZE_WIDTH / 8);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  line_idx;
  logic [WIDX_W-1:0] word_idx;
  logic [BUB_W-1:0]  bubble_cnt;

  logic req_rw, len_legal, rd_beat, wr_beat, last_word, last_line, line_load;

  assign req_rw    = req_valid && ((op == OP_READ) || (op == OP_WRITE));
  assign len_legal = (burst_len != '0) && (burst_len <= MAX_LEN);

  assign ready      = (state == ST_IDLE);
  assign busy       = (state != ST_STARTUP) && (state != ST_IDLE);
  assign host_rgo   = (state == ST_RD_REQ);
  assign host_re    = host_rgo && host_rd_ready;
  assign cpu_rvalid = (state == ST_RD_DRAIN);
  assign cpu_wready = (state == ST_WR_FILL);
  assign host_wgo   = (state == ST_WR_BUBBLE) || (state == ST_WR_REQ);
  assign host_we    = (state == ST_WR_REQ) && host_wr_ready;

  assign rd_beat   = cpu_rvalid && cpu_rready;
  assign wr_beat   = cpu_wready && cpu_wvalid;
  assign last_word = (word_idx == LAST_WORD);
  assign last_line = ((line_idx + LEN_ONE) == len_q);
  assign line_load = host_re;

  assign tx_done = (rd_beat && last_word && last_line) || (host_we && last_line);
  assign err_len = ready && req_rw && !len_legal;

  line_buffer_wordport #(
    .WORD_SIZE    (WORD_SIZE),
    .CL_SIZE_WIDTH(CL_SIZE_WIDTH)
  ) u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .load_en  (line_load),
    .load_data(host_data_bus_read_in),
    .wr_en    (wr_beat),
    .wr_idx   (word_idx),
    .wr_data  (cpu_wdata),
    .rd_idx   (word_idx),
    .rd_data  (cpu_rdata),
    .line     (host_data_bus_write_out)
  );

  // corrected_address tracks base + line_idx*LINE_BYTES by stepping once per finished line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_STARTUP;
      len_q             <= '0;
      line_idx          <= '0;
      word_idx          <= '0;
      bubble_cnt        <= '0;
      corrected_address <= '0;
    end else begin
      case (state)
        ST_STARTUP: begin
          if (host_init) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (req_rw && len_legal) begin
            len_q             <= burst_len;
            line_idx          <= '0;
            word_idx          <= '0;
            corrected_address <= raw_address + address_offset;
            state             <= (op == OP_READ) ? ST_RD_REQ : ST_WR_FILL;
          end
        end
        ST_RD_REQ: begin
          if (host_rd_ready) begin
            word_idx <= '0;
            state    <= ST_RD_DRAIN;
          end
        end
        ST_RD_DRAIN: begin
          if (rd_beat) begin
            word_idx <= word_idx + WORD_ONE;
            if (last_word) begin
              word_idx <= '0;
              if (last_line) begin
                state <= ST_IDLE;
              end else begin
                line_idx          <= line_idx + LEN_ONE;
                corrected_address <= corrected_address + LINE_STEP;
                state             <= ST_RD_REQ;
              end
            end
          end
        end
        ST_WR_FILL: begin
          if (wr_beat) begin
            word_idx <= word_idx + WORD_ONE;
            if (last_word) begin
              word_idx   <= '0;
              bubble_cnt <= '0;
              state      <= ST_WR_BUBBLE;
            end
          end
        end
        ST_WR_BUBBLE: begin
          if (bubble_cnt == LAST_BUBBLE) state <= ST_WR_REQ;
          else                           bubble_cnt <= bubble_cnt + BUB_ONE;
        end
        ST_WR_REQ: begin
          if (host_wr_ready) begin
            if (last_line) begin
              state <= ST_IDLE;
            end else begin
              line_idx          <= line_idx + LEN_ONE;
              corrected_address <= corrected_address + LINE_STEP;
              state             <= ST_WR_FILL;
            end
          end
        end
        default: state <= ST_STARTUP;
      endcase
    end
  end

endmodule
